// File: rtl/enemy_ctl_pkg.sv
// Shared definitions for the enemy blocks: FSM state and sweep direction encodings, coordinate width.
package enemy_ctl_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [2:0] {
        ST_SPAWN   = 3'd0,
        ST_MOVE_R  = 3'd1,
        ST_MOVE_L  = 3'd2,
        ST_DESCEND = 3'd3,
        ST_DEAD    = 3'd4
    } state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    // Counter width for a frame count; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vsync_tick.sv
// Frame tick generator: one-pclk pulse on each vsync_in rising edge.
// Latency: tick is high the cycle after vsync_in is first sampled high; no backpressure.
module vsync_tick (
    input  logic pclk,
    input  logic rst,
    input  logic vsync_in,
    output logic tick
);

    logic vs_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_d <= 1'b0;
            tick <= 1'b0;
        end else begin
            vs_d <= vsync_in;
            tick <= vsync_in & ~vs_d;
        end
    end

endmodule

// File: rtl/enemy_ctl.sv
// Single-enemy sweep controller: right, drop, left, drop; killed by hit, escapes past Y_LIMIT, respawns.
// Outputs registered, updated one pclk after the tick pulse; no backpressure (ticks dropped while disabled).
module enemy_ctl
    import enemy_ctl_pkg::*;
#(
    parameter int unsigned X_START        = 100,
    parameter int unsigned Y_START        = 50,
    parameter int unsigned X_MIN          = 0,
    parameter int unsigned X_MAX          = 1023,
    parameter int unsigned WIDTH          = 50,
    parameter int unsigned STEP           = 2,
    parameter int unsigned DROP_FRAMES    = 10,
    parameter int unsigned Y_LIMIT        = 700,
    parameter int unsigned RESPAWN_FRAMES = 120
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vsync_in,
    input  logic               enable,
    input  logic               hit,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic               on,
    output logic               killed,
    output logic               escaped
);

    localparam int DW = cnt_w(DROP_FRAMES);
    localparam int RW = cnt_w(RESPAWN_FRAMES);

    localparam logic [COORD_W-1:0] X_SPAWN   = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_SPAWN   = COORD_W'(Y_START);
    localparam logic [COORD_W-1:0] X_LEFT    = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] X_RIGHT   = COORD_W'(X_MAX - WIDTH);
    localparam logic [COORD_W-1:0] Y_END     = COORD_W'(Y_LIMIT);
    localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
    localparam logic [COORD_W:0]   STEP_E    = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0]   LEFT_TRIP = (COORD_W+1)'(X_MIN + STEP);
    localparam logic [DW-1:0]      DROP_LAST = DW'(DROP_FRAMES - 1);
    localparam logic [RW-1:0]      RESP_LAST = RW'(RESPAWN_FRAMES - 1);

    if (X_MIN + STEP > X_MAX - WIDTH) begin : g_bad_range
        $error("enemy_ctl: X_MIN+STEP must not exceed X_MAX-WIDTH");
    end

    logic          tick;
    state_t        state;
    dir_t          dir;
    logic [DW-1:0] drop_cnt;
    logic [RW-1:0] resp_cnt;

    // One bit wider than the coordinates so an edge compare can never wrap.
    logic [COORD_W:0] x_up;
    logic [COORD_W:0] y_up;
    assign x_up = {1'b0, xpos} + STEP_E;
    assign y_up = {1'b0, ypos} + STEP_E;

    vsync_tick u_vsync_tick (
        .pclk     (pclk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .tick     (tick)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= ST_SPAWN;
            dir      <= DIR_RIGHT;
            drop_cnt <= '0;
            resp_cnt <= '0;
            xpos     <= X_SPAWN;
            ypos     <= Y_SPAWN;
            on       <= 1'b0;
            killed   <= 1'b0;
            escaped  <= 1'b0;
        end else begin
            killed  <= 1'b0;
            escaped <= 1'b0;
            // A hit on a live enemy beats any motion or escape in the same cycle, even when disabled.
            if (hit && (state == ST_MOVE_R || state == ST_MOVE_L || state == ST_DESCEND)) begin
                on       <= 1'b0;
                killed   <= 1'b1;
                resp_cnt <= '0;
                state    <= ST_DEAD;
            end else if (tick && enable) begin
                case (state)
                    ST_SPAWN: begin
                        on    <= 1'b1;
                        xpos  <= X_SPAWN;
                        ypos  <= Y_SPAWN;
                        dir   <= DIR_RIGHT;
                        state <= ST_MOVE_R;
                    end
                    ST_MOVE_R: begin
                        if (x_up >= {1'b0, X_RIGHT}) begin
                            xpos     <= X_RIGHT;
                            dir      <= DIR_LEFT;
                            drop_cnt <= '0;
                            state    <= ST_DESCEND;
                        end else begin
                            xpos <= x_up[COORD_W-1:0];
                        end
                    end
                    ST_MOVE_L: begin
                        if ({1'b0, xpos} <= LEFT_TRIP) begin
                            xpos     <= X_LEFT;
                            dir      <= DIR_RIGHT;
                            drop_cnt <= '0;
                            state    <= ST_DESCEND;
                        end else begin
                            xpos <= xpos - STEP_C;
                        end
                    end
                    ST_DESCEND: begin
                        if (y_up >= {1'b0, Y_END}) begin
                            ypos     <= Y_END;
                            escaped  <= 1'b1;
                            on       <= 1'b0;
                            resp_cnt <= '0;
                            state    <= ST_DEAD;
                        end else begin
                            ypos <= y_up[COORD_W-1:0];
                            if (drop_cnt == DROP_LAST) begin
                                state <= (dir == DIR_LEFT) ? ST_MOVE_L : ST_MOVE_R;
                            end else begin
                                drop_cnt <= drop_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DEAD: begin
                        on <= 1'b0;
                        if (resp_cnt == RESP_LAST) begin
                            xpos     <= X_SPAWN;
                            ypos     <= Y_SPAWN;
                            resp_cnt <= '0;
                            state    <= ST_SPAWN;
                        end else begin
                            resp_cnt <= resp_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_SPAWN;
                endcase
            end
        end
    end

endmodule
